iir_cascade_tm: RTL

IIR_CASCADE_TM -- requirements
Module: iir_cascade_tm

---
 rtl/iir_cascade_tm.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/iir_cascade_tm.sv
// rtl/iir_cascade_tm.sv - cascade of direct-form-I biquads time-multiplexed over one multiplier
// One product per cycle: 5 MAC cycles + 1 UPDATE cycle per active section.
module iir_cascade_tm #(
  parameter int DW      = 16,
  parameter int CW      = 16,
  parameter int FRAC    = 14,
  parameter int MAX_SEC = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DW-1:0]           in_data,
  input  logic [3:0]                     order,
  input  logic                           coef_we,
  input  logic [$clog2(5*MAX_SEC)-1:0]   coef_addr,
  input  logic signed [CW-1:0]           coef_wdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DW-1:0]           out_data,
  output logic                           busy,
  output logic                           sat_flag
);
  localparam int NC   = 5 * MAX_SEC;
  localparam int AW   = $clog2(NC);
  localparam int SW   = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + 3;
  localparam logic signed [ACCW-1:0] RND  = ACCW'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [ACCW-1:0] YMAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {IDLE, MAC, UPDATE, OUT} state_t;
  state_t r_state, w_next;

  logic signed [CW-1:0]   r_coef [NC];
  logic signed [DW-1:0]   r_x1 [MAX_SEC];
  logic signed [DW-1:0]   r_x2 [MAX_SEC];
  logic signed [DW-1:0]   r_y1 [MAX_SEC];
  logic signed [DW-1:0]   r_y2 [MAX_SEC];
  logic [SW-1:0]          r_sec;
  logic [2:0]             r_k;
  logic [3:0]             r_order;
  logic signed [DW-1:0]   r_cur;
  logic signed [DW-1:0]   r_out;
  logic signed [ACCW-1:0] r_acc;
  logic                   r_sat;

  logic                   w_accept;
  logic                   w_more;
  logic [3:0]             w_ord_eff;
  logic [AW-1:0]          w_cidx;
  logic signed [CW-1:0]   w_c;
  logic signed [DW-1:0]   w_d;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_term;
  logic signed [ACCW-1:0] w_acc_base;
  logic signed [ACCW-1:0] w_acc_next;
  logic signed [ACCW-1:0] w_shf;
  logic signed [DW-1:0]   w_y;
  logic                   w_sat;

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out;
  assign sat_flag  = r_sat;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_ord_eff = (order > 4'(MAX_SEC)) ? 4'(MAX_SEC) : order;
  assign w_more    = (32'(r_sec) + 32'd1) < 32'(r_order);

  // Operand select for the single shared multiplier; k=3,4 are feedback terms.
  always_comb begin
    w_cidx = AW'(32'(r_sec) * 5 + 32'(r_k));
    w_c    = r_coef[w_cidx];
    case (r_k)
      3'd0:    w_d = r_cur;
      3'd1:    w_d = r_x1[r_sec];
      3'd2:    w_d = r_x2[r_sec];
      3'd3:    w_d = r_y1[r_sec];
      default: w_d = r_y2[r_sec];
    endcase
  end

  assign w_prod     = w_c * w_d;
  assign w_term     = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_base = (r_k == 3'd0) ? '0 : r_acc;
  assign w_acc_next = (r_k >= 3'd3) ? (w_acc_base - w_term) : (w_acc_base + w_term);
  assign w_shf      = (r_acc + RND) >>> FRAC;

  always_comb begin
    w_sat = 1'b0;
    w_y   = w_shf[DW-1:0];
    if (w_shf > YMAX) begin
      w_sat = 1'b1;
      w_y   = {1'b0, {(DW-1){1'b1}}};
    end else if (w_shf < YMIN) begin
      w_sat = 1'b1;
      w_y   = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_ord_eff == 4'd0) ? OUT : MAC;
      MAC:     if (r_k == 3'd4) w_next = UPDATE;
      UPDATE:  w_next = w_more ? MAC : OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) r_coef[i] <= '0;
      for (int s = 0; s < MAX_SEC; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
      r_sec   <= '0;
      r_k     <= '0;
      r_order <= '0;
      r_cur   <= '0;
      r_out   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (coef_we && (r_state == IDLE) && (32'(coef_addr) < NC))
        r_coef[coef_addr] <= coef_wdata;
      case (r_state)
        IDLE: if (w_accept) begin
          r_cur   <= in_data;
          r_order <= w_ord_eff;
          r_sec   <= '0;
          r_k     <= '0;
          // Sections beyond the active count restart from rest when re-enabled.
          for (int s = 0; s < MAX_SEC; s++) begin
            if (s >= int'(w_ord_eff)) begin
              r_x1[s] <= '0;
              r_x2[s] <= '0;
              r_y1[s] <= '0;
              r_y2[s] <= '0;
            end
          end
          if (w_ord_eff == 4'd0) r_out <= in_data;
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 3'd1;
        end
        UPDATE: begin
          r_x1[r_sec] <= r_cur;
          r_x2[r_sec] <= r_x1[r_sec];
          r_y1[r_sec] <= w_y;
          r_y2[r_sec] <= r_y1[r_sec];
          r_cur       <= w_y;
          r_k         <= '0;
          if (w_sat) r_sat <= 1'b1;
          if (w_more) r_sec <= r_sec + SW'(1);
          else        r_out <= w_y;
        end
        default: ;
      endcase
    end
  end
endmodule
